atoi_ctl: RTL and testbench

//  Sequencer that converts a TIB token to an integer by driving the 8-bit memory bus itself.
//  On start it reads chars from tib one at a time, decodes sign and digits, accumulates,
//  and reports value plus error flag with a done pulse. Sits beside the outer interpreter,

---
 rtl/forthsuper_pkg.sv | 31 +++
 rtl/atoi_ctl_if.sv | 28 ++
 rtl/a2d_dec.sv | 27 ++
 rtl/atoi_ctl.sv | 198 +++++++++++++++++++
 tb/tb_atoi_ctl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/forthsuper_pkg.sv
// Shared types and constants for the token-to-integer sequencer (atoi_ctl).
// Optional feature macro ATOI_CTL_PREFIX_EN enables '$'/'#' radix prefixes.
package forthsuper_pkg;

  localparam int unsigned ASZ = 17;
  localparam int unsigned DSZ = 32;
  localparam int unsigned LSZ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    EV   = 2'd2,
    FIN  = 2'd3
  } atoi_ctl_st;

  localparam logic [7:0] CH_NUL    = 8'h00;
  localparam logic [7:0] CH_SPC    = 8'h20;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_HASH   = 8'h23;

  localparam logic [4:0] DIG_BAD = 5'h10;

  // Request fields captured when a conversion is accepted
  typedef struct packed {
    logic [ASZ-1:0] tib;
    logic [LSZ-1:0] len;
  } atoi_req_t;

endpackage

// File: rtl/atoi_ctl_if.sv
// Request/result and memory-read bus of atoi_ctl.
// slave: the sequencer side; master: the requester plus memory side.
interface atoi_ctl_if;
  import forthsuper_pkg::*;

  logic           start;
  logic           hex;
  logic [ASZ-1:0] tib;
  logic [LSZ-1:0] len;
  logic           bsy;
  logic           done;
  logic           err;
  logic [DSZ-1:0] vo;
  logic [ASZ-1:0] mem_a;
  logic           mem_rd;
  logic [7:0]     mem_d;

  modport slave (
    input  start, hex, tib, len, mem_d,
    output bsy, done, err, vo, mem_a, mem_rd
  );

  modport master (
    output start, hex, tib, len, mem_d,
    input  bsy, done, err, vo, mem_a, mem_rd
  );

endinterface

// File: rtl/a2d_dec.sv
// Combinational ASCII-to-digit decoder; hex also accepts a-f / A-F.
// Invalid characters return DIG_BAD with dig_ok low.
module a2d_dec
  import forthsuper_pkg::*;
(
  input  logic [7:0] ch,
  input  logic       hex,
  output logic [4:0] dig,
  output logic       dig_ok
);

  always_comb begin
    dig    = DIG_BAD;
    dig_ok = 1'b0;
    if ((ch >= 8'h30) && (ch <= 8'h39)) begin
      dig    = 5'(ch - 8'h30);
      dig_ok = 1'b1;
    end else if (hex && (ch >= 8'h61) && (ch <= 8'h66)) begin
      dig    = 5'(ch - 8'h57);
      dig_ok = 1'b1;
    end else if (hex && (ch >= 8'h41) && (ch <= 8'h46)) begin
      dig    = 5'(ch - 8'h37);
      dig_ok = 1'b1;
    end
  end

endmodule

// File: rtl/atoi_ctl.sv
// Token-to-integer sequencer: reads TIB chars over the byte bus, accumulates, reports vo/err.
// Build option ATOI_CTL_PREFIX_EN: leading '$' forces hex, '#' forces decimal.
module atoi_ctl
  import forthsuper_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  atoi_ctl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RD   = RD;
  localparam logic [1:0] S_EV   = EV;
  localparam logic [1:0] S_FIN  = FIN;

  logic [1:0]     r_state, w_state;
  atoi_req_t      r_req, w_req;
  logic           r_hex, w_hex;
  logic [DSZ-1:0] r_acc, w_acc;
  logic           r_neg, w_neg;
  logic [LSZ-1:0] r_cnt, w_cnt;
  logic [LSZ-1:0] r_ndig, w_ndig;
  logic           r_bad, w_bad;
  logic           r_bsy, w_bsy;
  logic           r_done, w_done;
  logic           r_err, w_err;
  logic [DSZ-1:0] r_vo, w_vo;
  logic [ASZ-1:0] r_mem_a, w_mem_a;
  logic           r_mem_rd, w_mem_rd;
  logic           w_adv;
  logic           w_is_sign;
  logic           w_is_term;
  logic [4:0]     w_dig;
  logic           w_dig_ok;
`ifdef ATOI_CTL_PREFIX_EN
  logic           r_pfx, w_pfx;
  logic           w_pfx_ok;
`endif

  a2d_dec u_dec (
    .ch     (bus.mem_d),
    .hex    (r_hex),
    .dig    (w_dig),
    .dig_ok (w_dig_ok)
  );

  assign w_is_sign = (bus.mem_d == CH_MINUS) || (bus.mem_d == CH_PLUS);
  assign w_is_term = (bus.mem_d == CH_NUL) || (bus.mem_d == CH_SPC);

`ifdef ATOI_CTL_PREFIX_EN
  // A prefix may only follow nothing or a single sign, and only once
  assign w_pfx_ok = !r_pfx && (r_ndig == '0) && (r_cnt <= LSZ'(1));
`endif

  // Next-state and next-register values
  always_comb begin
    w_state  = r_state;
    w_req    = r_req;
    w_hex    = r_hex;
    w_acc    = r_acc;
    w_neg    = r_neg;
    w_cnt    = r_cnt;
    w_ndig   = r_ndig;
    w_bad    = r_bad;
    w_bsy    = r_bsy;
    w_done   = 1'b0;
    w_err    = r_err;
    w_vo     = r_vo;
    w_mem_a  = r_mem_a;
    w_mem_rd = 1'b0;
    w_adv    = 1'b0;
`ifdef ATOI_CTL_PREFIX_EN
    w_pfx    = r_pfx;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_req.tib = bus.tib;
          w_req.len = bus.len;
          w_hex     = bus.hex;
          w_acc     = '0;
          w_neg     = 1'b0;
          w_cnt     = '0;
          w_ndig    = '0;
          w_bad     = 1'b0;
          w_bsy     = 1'b1;
          w_err     = 1'b0;
          w_vo      = '0;
`ifdef ATOI_CTL_PREFIX_EN
          w_pfx     = 1'b0;
`endif
          if (bus.len == '0) begin
            w_bad   = 1'b1;
            w_state = S_FIN;
          end else begin
            w_state  = S_RD;
            w_mem_rd = 1'b1;
            w_mem_a  = bus.tib;
          end
        end
      end
      S_RD: begin
        w_state = S_EV;
      end
      S_EV: begin
        if (w_is_sign && (r_cnt == '0)) begin
          w_neg = (bus.mem_d == CH_MINUS);
          w_adv = 1'b1;
        end else if (w_dig_ok) begin
          w_acc  = r_hex ? ((r_acc << 4) | DSZ'(w_dig))
                         : ((r_acc << 3) + (r_acc << 1) + DSZ'(w_dig));
          w_ndig = r_ndig + LSZ'(1);
          w_adv  = 1'b1;
`ifdef ATOI_CTL_PREFIX_EN
        end else if (w_pfx_ok && ((bus.mem_d == CH_DOLLAR) || (bus.mem_d == CH_HASH))) begin
          w_hex = (bus.mem_d == CH_DOLLAR);
          w_pfx = 1'b1;
          w_adv = 1'b1;
`endif
        end else if (w_is_term) begin
          w_state = S_FIN;
        end else begin
          w_bad   = 1'b1;
          w_state = S_FIN;
        end
        // Consumed chars count toward len; the next read is issued directly
        if (w_adv) begin
          w_cnt = r_cnt + LSZ'(1);
          if (w_cnt == r_req.len) begin
            w_state = S_FIN;
          end else begin
            w_state  = S_RD;
            w_mem_rd = 1'b1;
            w_mem_a  = r_req.tib + ASZ'(w_cnt);
          end
        end
      end
      S_FIN: begin
        w_err   = r_bad || (r_ndig == '0);
        w_vo    = w_err ? '0 : (r_neg ? (~r_acc + DSZ'(1)) : r_acc);
        w_done  = 1'b1;
        w_bsy   = 1'b0;
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_req    <= '0;
      r_hex    <= 1'b0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_ndig   <= '0;
      r_bad    <= 1'b0;
      r_bsy    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_vo     <= '0;
      r_mem_a  <= '0;
      r_mem_rd <= 1'b0;
`ifdef ATOI_CTL_PREFIX_EN
      r_pfx    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state;
      r_req    <= w_req;
      r_hex    <= w_hex;
      r_acc    <= w_acc;
      r_neg    <= w_neg;
      r_cnt    <= w_cnt;
      r_ndig   <= w_ndig;
      r_bad    <= w_bad;
      r_bsy    <= w_bsy;
      r_done   <= w_done;
      r_err    <= w_err;
      r_vo     <= w_vo;
      r_mem_a  <= w_mem_a;
      r_mem_rd <= w_mem_rd;
`ifdef ATOI_CTL_PREFIX_EN
      r_pfx    <= w_pfx;
`endif
    end
  end

  assign bus.bsy    = r_bsy;
  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.vo     = r_vo;
  assign bus.mem_a  = r_mem_a;
  assign bus.mem_rd = r_mem_rd;

endmodule

// File: tb/tb_atoi_ctl.sv
// Directed table-driven bench for atoi_ctl with a byte-memory model and read log.
// Expectations for '$'/'#' follow the ATOI_CTL_PREFIX_EN build option.
module tb_atoi_ctl;
  import forthsuper_pkg::*;

  typedef struct {
    logic [127:0]   txt;
    int             nch;
    logic [7:0]     term;
    logic           hx;
    logic [ASZ-1:0] tib;
    logic [LSZ-1:0] len;
    logic [DSZ-1:0] vo;
    logic           err;
    int             cyc;
    int             nrd;
  } vec_t;

  logic clk;
  logic rst_n;
  atoi_ctl_if bus ();

  atoi_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0]     mem [64];
  logic [ASZ-1:0] rdq [$];
  int             rd_base;
  int             n_chk;
  int             n_pass;
  vec_t           vt [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memory: data valid the cycle after mem_rd
  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_d <= mem[bus.mem_a[5:0]];
      rdq.push_back(bus.mem_a);
    end
  end

  function automatic vec_t mk(input logic [127:0] txt, input int nch, input logic [7:0] term,
                              input logic hx, input logic [ASZ-1:0] tib, input logic [LSZ-1:0] len,
                              input logic [DSZ-1:0] vo, input logic err, input int cyc, input int nrd);
    vec_t v;
    v.txt = txt; v.nch = nch; v.term = term; v.hx = hx; v.tib = tib; v.len = len;
    v.vo = vo; v.err = err; v.cyc = cyc; v.nrd = nrd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 64; i++) mem[i] = 8'h7A;
    for (int i = 0; i < v.nch; i++) mem[6'(v.tib + ASZ'(i))] = v.txt[8*(v.nch-1-i) +: 8];
    mem[6'(v.tib + ASZ'(v.nch))] = v.term;
  endtask

  task automatic kick(input vec_t v);
    bus.start = 1'b1;
    bus.hex   = v.hx;
    bus.tib   = v.tib;
    bus.len   = v.len;
    rd_base   = rdq.size();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic result(input vec_t v, input int id, input int cyc);
    int nrd;
    check($sformatf("v%0d done", id), 64'(bus.done), 64'(1));
    check($sformatf("v%0d cycle", id), 64'(cyc), 64'(v.cyc));
    check($sformatf("v%0d err", id), 64'(bus.err), 64'(v.err));
    check($sformatf("v%0d vo", id), 64'(bus.vo), 64'(v.vo));
    check($sformatf("v%0d bsy", id), 64'(bus.bsy), 64'(0));
    nrd = rdq.size() - rd_base;
    check($sformatf("v%0d nreads", id), 64'(nrd), 64'(v.nrd));
    for (int j = 0; j < v.nrd && j < nrd; j++)
      check($sformatf("v%0d addr%0d", id, j), 64'(rdq[rd_base+j]), 64'(ASZ'(v.tib + ASZ'(j))));
    @(posedge clk);
    #1;
    check($sformatf("v%0d done pulse", id), 64'(bus.done), 64'(0));
    check($sformatf("v%0d vo held", id), 64'(bus.vo), 64'(v.vo));
  endtask

  task automatic run(input vec_t v, input int id);
    int cyc;
    load(v);
    kick(v);
    wait_done(1, cyc);
    result(v, id, cyc);
  endtask

  initial begin
    int   cyc;
    vec_t v0;
    n_chk = 0;
    n_pass = 0;
    rd_base = 0;
    bus.start = 1'b0;
    bus.hex = 1'b0;
    bus.tib = '0;
    bus.len = '0;
    rst_n = 1'b0;

    //          txt            nch term   hx  tib       len    vo            err cyc nrd
    vt.push_back(mk("123",        3, 8'h00, 0, 17'h10, 8'd8,  32'd123,        0, 10, 4));
    vt.push_back(mk("-ff",        3, 8'h20, 1, 17'h10, 8'd8,  32'hFFFFFF01,   0, 10, 4));
    vt.push_back(mk("FF",         2, 8'h00, 1, 17'h10, 8'd8,  32'd255,        0,  8, 3));
    vt.push_back(mk("12x4",       4, 8'h00, 0, 17'h10, 8'd8,  32'd0,          1,  8, 3));
    vt.push_back(mk("-",          1, 8'h00, 0, 17'h10, 8'd8,  32'd0,          1,  6, 2));
    vt.push_back(mk("5",          1, 8'h00, 0, 17'h10, 8'd0,  32'd0,          1,  2, 0));
    vt.push_back(mk("987654",     6, 8'h00, 0, 17'h10, 8'd3,  32'd987,        0,  8, 3));
    vt.push_back(mk("+7",         2, 8'h20, 0, 17'h10, 8'd8,  32'd7,          0,  8, 3));
    vt.push_back(mk("1-2",        3, 8'h00, 0, 17'h10, 8'd8,  32'd0,          1,  6, 2));
    vt.push_back(mk("123456789",  9, 8'h00, 1, 17'h10, 8'd16, 32'h23456789,   0, 22, 10));
    vt.push_back(mk("4294967297",10, 8'h00, 0, 17'h10, 8'd16, 32'd1,          0, 24, 11));
    vt.push_back(mk("-80000000",  9, 8'h00, 1, 17'h10, 8'd16, 32'h80000000,   0, 22, 10));
    vt.push_back(mk("-0",         2, 8'h00, 0, 17'h10, 8'd8,  32'd0,          0,  8, 3));
    vt.push_back(mk("42",         2, 8'h39, 0, 17'h10, 8'd2,  32'd42,         0,  6, 2));
    vt.push_back(mk("aG",         2, 8'h00, 1, 17'h10, 8'd8,  32'd0,          1,  6, 2));
    vt.push_back(mk("A",          1, 8'h00, 0, 17'h10, 8'd8,  32'd0,          1,  4, 1));
`ifdef ATOI_CTL_PREFIX_EN
    vt.push_back(mk("$1A",        3, 8'h00, 0, 17'h10, 8'd8,  32'd26,         0, 10, 4));
    vt.push_back(mk("#10",        3, 8'h00, 1, 17'h10, 8'd8,  32'd10,         0, 10, 4));
    vt.push_back(mk("-$ff",       4, 8'h00, 0, 17'h10, 8'd8,  32'hFFFFFF01,   0, 12, 5));
`else
    vt.push_back(mk("$1A",        3, 8'h00, 0, 17'h10, 8'd8,  32'd0,          1,  4, 1));
    vt.push_back(mk("#10",        3, 8'h00, 1, 17'h10, 8'd8,  32'd0,          1,  4, 1));
    vt.push_back(mk("-$ff",       4, 8'h00, 0, 17'h10, 8'd8,  32'd0,          1,  6, 2));
`endif
    vt.push_back(mk("12",         2, 8'h00, 0, 17'h1FFFF, 8'd8, 32'd12,       0,  8, 3));
    v0 = vt[0];

    repeat (2) @(posedge clk);
    #1;
    check("rst bsy", 64'(bus.bsy), 64'(0));
    check("rst done", 64'(bus.done), 64'(0));
    check("rst err", 64'(bus.err), 64'(0));
    check("rst vo", 64'(bus.vo), 64'(0));
    check("rst mem_rd", 64'(bus.mem_rd), 64'(0));
    check("rst mem_a", 64'(bus.mem_a), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) run(vt[i], i);

    // start while busy is dropped
    load(v0);
    kick(v0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.tib = 17'h0;
    bus.len = 8'd1;
    bus.hex = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(3, cyc);
    result(v0, 100, cyc);

    // start in the done cycle is accepted
    load(v0);
    kick(v0);
    wait_done(1, cyc);
    check("b2b first vo", 64'(bus.vo), 64'(123));
    kick(v0);
    check("b2b bsy", 64'(bus.bsy), 64'(1));
    check("b2b done", 64'(bus.done), 64'(0));
    wait_done(1, cyc);
    result(v0, 101, cyc);

    // async reset while evaluating a char
    load(v0);
    kick(v0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid rst bsy", 64'(bus.bsy), 64'(0));
    check("mid rst done", 64'(bus.done), 64'(0));
    check("mid rst err", 64'(bus.err), 64'(0));
    check("mid rst vo", 64'(bus.vo), 64'(0));
    check("mid rst mem_rd", 64'(bus.mem_rd), 64'(0));
    check("mid rst mem_a", 64'(bus.mem_a), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run(v0, 102);
    run(vt[1], 103);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
